// File: rtl/vram_wr_arb_if.sv
// Camera/CPU write sources and VRAM port A bundle.
// VRAM_ARB_DROP_CNT_EN adds the drop_cnt signal.
interface vram_wr_arb_if;
  logic        cam_sof;
  logic        cam_vld;
  logic [11:0] cam_pix;
  logic        cpu_req;
  logic [13:0] cpu_addr;
  logic [11:0] cpu_data;
  logic        cpu_ack;
  logic        vram_wea;
  logic [13:0] vram_addra;
  logic [11:0] vram_dina;
  logic        fifo_ovf;
  logic        frame_done;
`ifdef VRAM_ARB_DROP_CNT_EN
  logic [15:0] drop_cnt;

  modport master (
    output cam_sof, cam_vld, cam_pix,
    output cpu_req, cpu_addr, cpu_data,
    input  cpu_ack, vram_wea, vram_addra,
    input  vram_dina, fifo_ovf, frame_done,
    input  drop_cnt
  );

  modport slave (
    input  cam_sof, cam_vld, cam_pix,
    input  cpu_req, cpu_addr, cpu_data,
    output cpu_ack, vram_wea, vram_addra,
    output vram_dina, fifo_ovf, frame_done,
    output drop_cnt
  );
`else
  modport master (
    output cam_sof, cam_vld, cam_pix,
    output cpu_req, cpu_addr, cpu_data,
    input  cpu_ack, vram_wea, vram_addra,
    input  vram_dina, fifo_ovf, frame_done
  );

  modport slave (
    input  cam_sof, cam_vld, cam_pix,
    input  cpu_req, cpu_addr, cpu_data,
    output cpu_ack, vram_wea, vram_addra,
    output vram_dina, fifo_ovf, frame_done
  );
`endif
endinterface

// File: rtl/vram_wr_arb.sv
// VRAM port A write arbiter: buffered camera stream vs CPU req/ack.
// Optional VRAM_ARB_DROP_CNT_EN adds a saturating dropped-pixel counter.
module vram_wr_arb #(
  parameter int FRAME_PIX    = 12288,
  parameter int FIFO_DEPTH   = 4,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  vram_wr_arb_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [13:0] LAST  = 14'(FRAME_PIX - 1);
  localparam logic [7:0]  MAXW  = 8'(CPU_MAX_WAIT);
  localparam logic [AW:0] P_ONE = (AW + 1)'(1);

  logic [25:0] mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [13:0] cam_cnt;
  logic [13:0] push_addr;
  logic [7:0]  starve_cnt;
  logic [25:0] head;
  logic        empty;
  logic        full;
  logic        cpu_elig;
  logic        cam_gnt;
  logic        cpu_gnt;
  logic        push;
  logic        drop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign head  = mem[rptr[AW-1:0]];

  // Arbitration, push/drop decision and camera address selection
  always_comb begin
    cpu_elig  = 1'b0;
    cam_gnt   = 1'b0;
    cpu_gnt   = 1'b0;
    push      = 1'b0;
    drop      = 1'b0;
    push_addr = cam_cnt;
    cpu_elig  = bus.cpu_req && !bus.cpu_ack;
    if (bus.cam_sof)
      push_addr = 14'd0;
    unique case (1'b1)
      (!empty && cpu_elig): begin
        if (starve_cnt == MAXW) cpu_gnt = 1'b1;
        else                    cam_gnt = 1'b1;
      end
      (!empty && !cpu_elig): cam_gnt = 1'b1;
      (empty && cpu_elig):   cpu_gnt = 1'b1;
      default: ;
    endcase
    push = bus.cam_vld && (!full || cam_gnt);
    drop = bus.cam_vld && full && !cam_gnt;
  end

  // FIFO storage, written without reset
  always_ff @(posedge clk) begin
    if (push)
      mem[wptr[AW-1:0]] <= {push_addr, bus.cam_pix};
  end

  // FIFO pointers and camera address counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= '0;
      rptr    <= '0;
      cam_cnt <= 14'd0;
    end else begin
      if (push)    wptr <= wptr + P_ONE;
      if (cam_gnt) rptr <= rptr + P_ONE;
      if (bus.cam_vld)
        cam_cnt <= (push_addr == LAST) ? 14'd0 : push_addr + 14'd1;
    end
  end

  // CPU starvation counter, saturating at the forced-grant threshold
  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= 8'd0;
    else if (!bus.cpu_req || cpu_gnt)
      starve_cnt <= 8'd0;
    else if (cpu_elig && starve_cnt != MAXW)
      starve_cnt <= starve_cnt + 8'd1;
  end

  // Registered VRAM write port, ack, frame marker and sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.vram_wea   <= 1'b0;
      bus.vram_addra <= 14'd0;
      bus.vram_dina  <= 12'd0;
      bus.cpu_ack    <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.fifo_ovf   <= 1'b0;
    end else begin
      bus.vram_wea   <= cam_gnt || cpu_gnt;
      bus.cpu_ack    <= cpu_gnt;
      bus.frame_done <= cam_gnt && (head[25:12] == LAST);
      if (cpu_gnt) begin
        bus.vram_addra <= bus.cpu_addr;
        bus.vram_dina  <= bus.cpu_data;
      end else if (cam_gnt) begin
        bus.vram_addra <= head[25:12];
        bus.vram_dina  <= head[11:0];
      end
      if (drop)
        bus.fifo_ovf <= 1'b1;
      else if (bus.cam_sof)
        bus.fifo_ovf <= 1'b0;
    end
  end

`ifdef VRAM_ARB_DROP_CNT_EN
  // Lifetime dropped-pixel count, only reset clears it
  always_ff @(posedge clk) begin
    if (rst)
      bus.drop_cnt <= 16'd0;
    else if (drop && bus.drop_cnt != 16'hFFFF)
      bus.drop_cnt <= bus.drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_vram_wr_arb.sv
// Directed bench for vram_wr_arb: reset, frame stream, CPU,
// contention, overflow and mid-frame reset.
module tb_vram_wr_arb;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cam_exp;

  vram_wr_arb_if bus();

  vram_wr_arb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".wea"}, 32'(bus.vram_wea), 32'd0);
    chk({tag, ".ack"}, 32'(bus.cpu_ack), 32'd0);
    chk({tag, ".fd"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic chk_cam(input string tag, input int a,
                         input int d, input bit fd);
    chk({tag, ".wea"}, 32'(bus.vram_wea), 32'd1);
    chk({tag, ".ack"}, 32'(bus.cpu_ack), 32'd0);
    chk({tag, ".addr"}, 32'(bus.vram_addra), 32'(a));
    chk({tag, ".dina"}, 32'(bus.vram_dina), 32'(d));
    chk({tag, ".fd"}, 32'(bus.frame_done), 32'(fd));
  endtask

  task automatic chk_cpu(input string tag, input int a, input int d);
    chk({tag, ".wea"}, 32'(bus.vram_wea), 32'd1);
    chk({tag, ".ack"}, 32'(bus.cpu_ack), 32'd1);
    chk({tag, ".addr"}, 32'(bus.vram_addra), 32'(a));
    chk({tag, ".dina"}, 32'(bus.vram_dina), 32'(d));
    chk({tag, ".fd"}, 32'(bus.frame_done), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk_idle(tag);
    chk({tag, ".addr"}, 32'(bus.vram_addra), 32'd0);
    chk({tag, ".dina"}, 32'(bus.vram_dina), 32'd0);
    chk({tag, ".ovf"}, 32'(bus.fifo_ovf), 32'd0);
`ifdef VRAM_ARB_DROP_CNT_EN
    chk({tag, ".drop_cnt"}, 32'(bus.drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    // reset held 3 cycles with both sources active
    rst          = 1'b1;
    bus.cam_sof  = 1'b0;
    bus.cam_vld  = 1'b1;
    bus.cam_pix  = 12'h5A5;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 14'h0100;
    bus.cpu_data = 12'hABC;
    repeat (3) begin
      step();
      chk_zero("rst");
    end

    // CPU alone: write at cycle 1, next ack at cycle 3
    rst         = 1'b0;
    bus.cam_vld = 1'b0;
    step();
    chk_cpu("cpu1", 'h0100, 'hABC);
    step();
    chk_idle("cpu_lock");
    chk("cpu_lock.addr", 32'(bus.vram_addra), 32'h0100);
    step();
    chk_cpu("cpu2", 'h0100, 'hABC);
    bus.cpu_req = 1'b0;
    step();
    chk_idle("cpu_rel");

    // full frame plus two pixels, pix = addr
    for (int i = 0; i <= 12289; i++) begin
      bus.cam_sof = (i == 0);
      bus.cam_vld = 1'b1;
      bus.cam_pix = 12'(i);
      step();
      if (i == 0)
        chk_idle("cam_lat");
      else
        chk_cam("frame", (i - 1) % 12288, (i - 1) % 4096,
                (i - 1) == 12287);
    end
    bus.cam_sof = 1'b0;
    bus.cam_vld = 1'b0;
    step();
    chk_cam("wrap", 1, 1, 1'b0);
    step();
    chk_idle("frame_end");
    chk("frame.ovf", 32'(bus.fifo_ovf), 32'd0);

    // contention: CPU forced every 10 cycles, FIFO fills, drop at 39
    bus.cpu_addr = 14'h2A5A;
    bus.cpu_data = 12'h5C3;
    cam_exp = 0;
    for (int c = 0; c < 40; c++) begin
      bus.cam_sof = (c == 0);
      bus.cam_vld = 1'b1;
      bus.cam_pix = 12'(c + 100);
      bus.cpu_req = (c >= 1);
      step();
      if (c == 0)
        chk_idle("cont0");
      else if (c == 9 || c == 19 || c == 29 || c == 39)
        chk_cpu("cont_cpu", 'h2A5A, 'h5C3);
      else begin
        chk_cam("cont_cam", cam_exp, cam_exp + 100, 1'b0);
        cam_exp++;
      end
      chk("cont.ovf", 32'(bus.fifo_ovf), 32'(c == 39));
    end

    // drain 35..38, pixel 39 was dropped
    bus.cam_sof = 1'b0;
    bus.cam_vld = 1'b0;
    bus.cpu_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk_cam("drain", 35 + k, 135 + k, 1'b0);
    end
    step();
    chk_idle("drain_end");

    // next pixel lands on address 40
    bus.cam_vld = 1'b1;
    bus.cam_pix = 12'h321;
    step();
    chk_idle("skip_lat");
    bus.cam_vld = 1'b0;
    step();
    chk_cam("skip", 40, 'h321, 1'b0);
    chk("skip.ovf", 32'(bus.fifo_ovf), 32'd1);

    // cam_sof clears the sticky flag
    bus.cam_sof = 1'b1;
    bus.cam_vld = 1'b1;
    bus.cam_pix = 12'h0AA;
    step();
    chk("sof.ovf", 32'(bus.fifo_ovf), 32'd0);
`ifdef VRAM_ARB_DROP_CNT_EN
    chk("sof.drop_cnt", 32'(bus.drop_cnt), 32'd1);
`endif
    bus.cam_sof = 1'b0;
    bus.cam_vld = 1'b0;
    step();
    chk_cam("sof_wr", 0, 'h0AA, 1'b0);

    // mid-frame reset at pixel 500
    for (int i = 0; i < 500; i++) begin
      bus.cam_sof = (i == 0);
      bus.cam_vld = 1'b1;
      bus.cam_pix = 12'(i);
      step();
      if (i == 499)
        chk_cam("pre_rst", 498, 498, 1'b0);
    end
    rst         = 1'b1;
    bus.cam_pix = 12'(500);
    step();
    chk_zero("mid_rst");
    rst         = 1'b0;
    bus.cam_vld = 1'b0;
    step();
    chk_idle("rst_flush");
    bus.cam_vld = 1'b1;
    bus.cam_pix = 12'h777;
    step();
    chk_idle("rst_lat");
    bus.cam_vld = 1'b0;
    step();
    chk_cam("rst_addr0", 0, 'h777, 1'b0);
    step();
    chk_idle("done");

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_wr_arb.md
Name: vram_wr_arb

Overview:
Write-port controller for the 14-bit-address, 12-bit-data camera VRAM. It shares the single VRAM write port (wea/addra/dina) between two sources. The first is the camera capture stream, which cannot stall; it is buffered in a small FIFO and given linear frame addresses. The second is the ZPUino CPU path, using a req/ack handshake. The block sits between the camera pixel formatter and VRAM port A; it issues at most one write per clock.

Parameters:
FRAME_PIX, 12288, pixels per frame (128x96); camera address wraps from FRAME_PIX-1 to 0; legal range 2..16384
FIFO_DEPTH, 4, camera FIFO entries, power of two, 2..16
CPU_MAX_WAIT, 8, cycles cpu_req may be denied while camera data is pending before the CPU grant is forced; 1..255

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
cam_sof  in  1  start of frame; camera address counter restarts at 0 for the pixel accepted this cycle
cam_vld  in  1  cam_pix valid this cycle
cam_pix  in  12  camera pixel
cpu_req  in  1  CPU write request; hold until cpu_ack
cpu_addr  in  14  CPU write address, stable while cpu_req is high
cpu_data  in  12  CPU write data, stable while cpu_req is high
cpu_ack  out  1  one-cycle pulse, coincident with the VRAM write of the CPU request
vram_wea  out  1  to VRAM wea
vram_addra  out  14  to VRAM addra
vram_dina  out  12  to VRAM dina
fifo_ovf  out  1  sticky: a camera pixel was dropped; cleared by rst or cam_sof
frame_done  out  1  one-cycle pulse with the camera write to address FRAME_PIX-1

Behaviour:
- Single clock, rst is synchronous and active-high. While rst=1: FIFO emptied, camera address=0, starve counter=0, all outputs 0. A CPU request pending at reset is not acked; a held cpu_req is re-arbitrated after reset.
- Camera push: when cam_vld=1, {cam_addr, cam_pix} is pushed.
  - cam_addr is the running counter, or 0 if cam_sof=1 that cycle.
  - The counter then becomes pushed address+1, wrapping FRAME_PIX-1 -> 0.
  - The counter advances even if the pixel is dropped, so frame geometry is preserved.
- FIFO full with cam_vld=1 and no pop that cycle: pixel dropped, fifo_ovf set.
- Full with simultaneous pop: push accepted, no drop.
- No bypass: a pushed entry is eligible for arbitration the next cycle.
- Arbitration is evaluated every cycle (cycle N); outputs are registered and valid at N+1.
  - CPU eligible: cpu_req=1 and cpu_ack=0. Lockout during the ack cycle prevents double grant, giving a max CPU rate of 1 write per 2 cycles.
  - FIFO non-empty and CPU eligible: camera wins unless starve_cnt == CPU_MAX_WAIT, in which case CPU wins.
  - Only one source eligible: that source wins.
  - Neither eligible: vram_wea=0; vram_addra/vram_dina hold their previous values.
- starve_cnt:
  - Increments, saturating at CPU_MAX_WAIT, in each cycle the CPU is eligible but denied.
  - Clears on CPU grant, or when cpu_req=0.
- Camera grant: FIFO pops in cycle N; at N+1, vram_wea=1 with the entry's address and data. frame_done=1 if the address is FRAME_PIX-1.
- CPU grant: at N+1, vram_wea=1, vram_addra=cpu_addr, vram_dina=cpu_data sampled at N, cpu_ack=1.
- Latency, idle block: cam_vld at cycle 0 -> vram_wea at cycle 2. cpu_req at cycle 0 -> write and ack at cycle 1.
- cam_sof: clears fifo_ovf, except when a drop occurs in the same cycle, where set wins. Entries already in the FIFO are written unchanged.
- frame_done and cpu_ack are never asserted together.

Optional Feature:
VRAM_ARB_DROP_CNT_EN
- Defined: adds output port drop_cnt (out, 16). It increments once per dropped camera pixel, saturates at 16'hFFFF, is cleared only by rst, and is not affected by cam_sof.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst 3 cycles with cam_vld=1, cpu_req=1 -> all outputs 0 throughout. First write occurs after rst falls: CPU at cycle 1 (FIFO was held empty).
- Camera stream: cam_sof+cam_vld cycle 0, cam_vld continuous with pix=addr, 12288 cycles -> writes to addr 0..12287 in order, 2-cycle latency, frame_done only with addr 12287, next pixel writes addr 0, fifo_ovf=0.
- CPU alone: cpu_req held with addr 0x0100, data 0xABC -> one write at cycle 1 with cpu_ack; next ack no earlier than cycle 3; data matches.
- Contention: continuous camera plus held cpu_req -> camera writes for 8 cycles, then the forced CPU write with ack. Pattern repeats with CPU_MAX_WAIT=8.
- Overflow: FIFO filled, then CPU forced, then cam_vld for one extra pixel -> that pixel is dropped, fifo_ovf=1, and its address is skipped (next written address +2). Next cam_sof clears fifo_ovf; with VRAM_ARB_DROP_CNT_EN, drop_cnt=1.
- Mid-frame reset: rst for 1 cycle at pixel 500 -> FIFO discarded. The next cam_vld without cam_sof writes addr 0.
